fifo_word_packer: RTL
=====================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of one FIFO entry in bits.
REQ-002 The block SHALL have parameter PACK, default 4, meaning the number of FIFO entries per output word (range 2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the number of idle cycles before a partial-word flush (range 1..255).
REQ-004 clkb  input  1  Read-domain clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  Synchronous, active-high reset, sampled on the clkb rising edge.
REQ-006 empty  input  1  Upstream FIFO empty flag.
REQ-007 rd_en  output  1  Read request to the upstream FIFO.
REQ-008 rdata  input  DATA_WIDTH  Upstream FIFO read data.
REQ-009 m_data  output  DATA_WIDTH*PACK  Packed word; entry 0 in the LSBs.
REQ-010 m_keep  output  PACK  Lane-valid mask; bit i qualifies lane i.
REQ-011 m_valid  output  1  Output word valid.
REQ-012 m_ready  input  1  Downstream accept.

Function
REQ-013 rdata SHALL be captured exactly one cycle after a cycle in which rd_en=1 and empty=0; a cycle with rd_en=1 and empty=1 SHALL NOT be counted as a read.
REQ-014 The FSM SHALL have two states: FILL (collecting entries) and HOLD (word presented).
REQ-015 In FILL, rd_en SHALL equal !empty && (count + inflight < PACK), where count is the number of captured lanes and inflight (0 or 1) is the number of reads issued but not yet captured.
REQ-016 Captured entries SHALL be written to lane count, starting at lane 0; count SHALL be ceil(log2(PACK+1)) bits wide and SHALL never exceed PACK.
REQ-017 When the capture of lane PACK-1 occurs, the next state SHALL be HOLD, with m_valid=1 and m_keep all ones in the following cycle.
REQ-018 In HOLD, rd_en SHALL be 0, and m_data, m_keep, and m_valid SHALL remain stable until m_valid && m_ready.
REQ-019 On m_valid && m_ready, the next cycle SHALL have m_valid=0, count=0, m_keep=0, and state FILL; m_data MAY retain stale lanes.
REQ-020 m_ready SHALL be ignored while m_valid=0.
REQ-021 Throughput SHALL be at least one word per PACK+2 cycles when empty=0 and m_ready=1 continuously.
REQ-022 An empty flag that rises while a read is in flight SHALL NOT discard that read; the in-flight entry SHALL still be captured.

Reset
REQ-023 While reset=1 at a clkb edge, the next cycle SHALL have rd_en=0, m_valid=0, m_keep=0, m_data=0, count=0, inflight=0, idle timer=0, and state FILL.
REQ-024 Reset SHALL override all other events, including a pending capture or a handshake in the same cycle; partially packed data SHALL be discarded.
REQ-025 rd_en SHALL be 0 in the first cycle after reset deasserts.

Configuration
REQ-026 The macro PACKER_TIMEOUT_EN SHALL control the partial-word flush feature.
REQ-027 With PACKER_TIMEOUT_EN defined, an 8-bit idle timer SHALL count cycles in FILL with count>0 and no capture, and SHALL clear on any capture.
REQ-028 With PACKER_TIMEOUT_EN defined, when the idle timer reaches TIMEOUT with inflight=0, the block SHALL enter HOLD with m_valid=1 and m_keep holding ones only in lanes 0..count-1.
REQ-029 With PACKER_TIMEOUT_EN defined, the idle timer SHALL be held at 0 in HOLD and when count=0.
REQ-030 Without PACKER_TIMEOUT_EN, no timer logic SHALL exist, partial words SHALL wait indefinitely, and m_keep SHALL be all ones whenever m_valid=1.

Verification
REQ-031 Scenario 1: after reset, with empty=0 and rdata sequence 0x11,0x22,0x33,0x44, m_ready=1 -> m_data=0x44332211, m_keep=4'hF, m_valid high for one cycle.
REQ-032 Scenario 2: word ready with m_ready=0 for 10 cycles -> rd_en=0 and m_data stable throughout; m_ready=1 -> accepted, FILL resumes next cycle.
REQ-033 Scenario 3: empty toggled every cycle during 8 entries 0x01..0x08 -> two words, 0x04030201 then 0x08070605, with no lost or duplicated entries.
REQ-034 Scenario 4: empty rises in the cycle after rd_en with a read in flight -> the in-flight entry is captured and count increments.
REQ-035 Scenario 5: reset asserted with count=3 and a read in flight -> next cycle m_valid=0 and count=0, and the next word contains only post-reset data.
REQ-036 Scenario 6 (PACKER_TIMEOUT_EN, TIMEOUT=16): two entries 0xAA,0xBB followed by empty held at 1 -> m_valid exactly 16 idle cycles after the last capture, m_keep=4'b0011, m_data[15:0]=0xBBAA; without the macro, m_valid stays 0.

Source files
------------

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: packs PACK upstream FIFO entries into one wide output word.
// Optional partial-word flush on idle timeout when PACKER_TIMEOUT_EN is defined.
`default_nettype none

module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clkb,
  input  logic                       reset,
  input  logic                       empty,
  output logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int            CW        = $clog2(PACK + 1);
  localparam logic [0:0]    S_FILL    = 1'b0;
  localparam logic [0:0]    S_HOLD    = 1'b1;
  localparam logic [CW:0]   PACK_W    = (CW + 1)'(PACK);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

  logic [0:0]                 state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       inflight_q, inflight_d;
  logic                       started_q;
  logic [DATA_WIDTH*PACK-1:0] data_q, data_d;
  logic [PACK-1:0]            keep_q, keep_d;

  logic w_room;
  logic w_rd_en;
  logic w_rd_fire;

  // Reads are held off for one cycle after reset so rd_en starts low.
  assign w_room    = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < PACK_W;
  assign w_rd_en   = started_q && (state_q == S_FILL) && !empty && w_room;
  assign w_rd_fire = w_rd_en && !empty;

  assign rd_en   = w_rd_en;
  assign m_valid = (state_q == S_HOLD);
  assign m_keep  = keep_q;
  assign m_data  = data_q;

`ifdef PACKER_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  logic [7:0]      idle_q, idle_d;
  logic            w_flush;
  logic [PACK-1:0] w_part_keep;

  // A flush is suppressed while a read is issued so the in-flight entry is never lost.
  always_comb begin
    w_flush = (state_q == S_FILL) && (count_q != '0) && !inflight_q && !w_rd_fire &&
              (({1'b0, idle_q} + 9'd1) >= TIMEOUT_W);
    idle_d = idle_q;
    if ((state_q != S_FILL) || (count_q == '0) || inflight_q || w_flush) begin
      idle_d = '0;
    end else if (idle_q != 8'hFF) begin
      idle_d = idle_q + 8'd1;
    end
    w_part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      w_part_keep[i] = (CW'(i) < count_q);
    end
  end

  always_ff @(posedge clkb) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic w_timeout_unused;
  assign w_timeout_unused = |8'(TIMEOUT);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    keep_d     = keep_q;
    data_d     = data_q;
    inflight_d = w_rd_fire;
    case (state_q)
      S_FILL: begin
        if (inflight_q) begin
          for (int i = 0; i < PACK; i++) begin
            if (count_q == CW'(i)) begin
              data_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
          end
          count_d = count_q + CW'(1);
          if (count_q == LAST_LANE) begin
            state_d = S_HOLD;
            keep_d  = '1;
          end
        end
`ifdef PACKER_TIMEOUT_EN
        else if (w_flush) begin
          state_d = S_HOLD;
          keep_d  = w_part_keep;
        end
`endif
      end
      default: begin
        if (m_ready) begin
          state_d = S_FILL;
          count_d = '0;
          keep_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clkb) begin
    if (reset) begin
      state_q    <= S_FILL;
      count_q    <= '0;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      started_q  <= 1'b1;
      data_q     <= data_d;
      keep_q     <= keep_d;
    end
  end

endmodule

`default_nettype wire
